// File: rtl/module_ascii_tx_sequencer_pkg.sv
// Shared types and byte constants for the ASCII TX sequencer.
package module_ascii_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_C,
        SEND_D,
        SEND_U,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/module_bcd2ascii.sv
// Combinational single BCD digit to ASCII character converter.
module module_bcd2ascii (
    input  logic [3:0] i_bcd,
    output logic [7:0] o_ascii
);

    assign o_ascii = 8'h30 + {4'h0, i_bcd};

endmodule

// File: rtl/module_binary_to_bcd.sv
// Combinational 8-bit binary to three-digit BCD converter.
module module_binary_to_bcd (
    input  logic [7:0] i_bin,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    // Divisors are constants, so these reduce to small fixed logic.
    assign o_hundreds = 4'(i_bin / 8'd100);
    assign o_tens     = 4'((i_bin % 8'd100) / 8'd10);
    assign o_units    = 4'(i_bin % 8'd10);

endmodule

// File: rtl/module_ascii_tx_sequencer.sv
// Converts one latched 8-bit sample to decimal ASCII and streams it to UART TX
// over valid/ready, optionally dropping leading zeros and appending CR/LF.
module module_ascii_tx_sequencer
    import module_ascii_tx_sequencer_pkg::*;
#(
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit APPEND_CRLF    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       done_o
);

    state_t     r_state;
    logic [7:0] r_sample;
    logic [7:0] r_asc_t;
    logic [7:0] r_asc_u;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_bcd_h, w_bcd_t, w_bcd_u;
    logic [7:0] w_asc_h, w_asc_t, w_asc_u;
    logic       w_hs;

    module_binary_to_bcd u_bin2bcd (
        .i_bin      (r_sample),
        .o_hundreds (w_bcd_h),
        .o_tens     (w_bcd_t),
        .o_units    (w_bcd_u)
    );

    module_bcd2ascii u_asc_h (.i_bcd(w_bcd_h), .o_ascii(w_asc_h));
    module_bcd2ascii u_asc_t (.i_bcd(w_bcd_t), .o_ascii(w_asc_t));
    module_bcd2ascii u_asc_u (.i_bcd(w_bcd_u), .o_ascii(w_asc_u));

    assign w_hs = r_tx_valid && tx_ready_i;

    // Each state loads the byte of the next state on its handshake, so
    // tx_data_o/tx_valid_o are purely registered and hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sample   <= 8'h00;
            r_asc_t    <= ASCII_ZERO;
            r_asc_u    <= ASCII_ZERO;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_sample <= data_i;
                        r_busy   <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_asc_t    <= w_asc_t;
                    r_asc_u    <= w_asc_u;
                    r_tx_valid <= 1'b1;
                    if (!SUPPRESS_ZEROS || w_bcd_h != 4'd0) begin
                        r_state   <= SEND_C;
                        r_tx_data <= w_asc_h;
                    end else if (w_bcd_t != 4'd0) begin
                        r_state   <= SEND_D;
                        r_tx_data <= w_asc_t;
                    end else begin
                        r_state   <= SEND_U;
                        r_tx_data <= w_asc_u;
                    end
                end
                SEND_C: begin
                    if (w_hs) begin
                        r_state   <= SEND_D;
                        r_tx_data <= r_asc_t;
                    end
                end
                SEND_D: begin
                    if (w_hs) begin
                        r_state   <= SEND_U;
                        r_tx_data <= r_asc_u;
                    end
                end
                SEND_U: begin
                    if (w_hs) begin
                        if (APPEND_CRLF) begin
                            r_state   <= SEND_CR;
                            r_tx_data <= ASCII_CR;
                        end else begin
                            r_state    <= IDLE;
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                SEND_CR: begin
                    if (w_hs) begin
                        r_state   <= SEND_LF;
                        r_tx_data <= ASCII_LF;
                    end
                end
                SEND_LF: begin
                    if (w_hs) begin
                        r_state    <= IDLE;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_o  = r_tx_data;
    assign tx_valid_o = r_tx_valid;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_module_ascii_tx_sequencer.sv
// Bench: vector table plus hand sequences; bytes checked against a queue at each handshake.
module tb_module_ascii_tx_sequencer;

    typedef struct {
        bit          sel;    // 0: default instance, 1: no-suppress/no-CRLF instance
        logic [7:0]  data;
        int          len;
        logic [39:0] bytes;  // expected bytes, first byte in the top octet
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_ready = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic [7:0] txd_a, txd_b;
    logic       txv_a, txv_b, busy_a, busy_b, done_a, done_b;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    module_ascii_tx_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .data_i(data_a),
        .tx_data_o(txd_a), .tx_valid_o(txv_a), .tx_ready_i(tx_ready),
        .busy_o(busy_a), .done_o(done_a)
    );

    module_ascii_tx_sequencer #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .data_i(data_b),
        .tx_data_o(txd_b), .tx_valid_o(txv_b), .tx_ready_i(tx_ready),
        .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h want 0x%02h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        n_chk++;
        $display("FAIL %s: got byte 0x%02h want none at %0t", name, act, $time);
    endtask

    // Scoreboard monitors: a byte is consumed on each negedge where valid&&ready.
    initial begin
        logic       stall;
        logic [7:0] held;
        stall = 1'b0;
        held  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) stall = 1'b0;
            else begin
                if (stall) begin
                    chk1("a_hold_valid", txv_a, 1'b1);
                    chk8("a_hold_data", txd_a, held);
                end
                if (txv_a && tx_ready) begin
                    if (q_a.size() == 0) unexpected("a_extra_byte", txd_a);
                    else chk8("a_byte", txd_a, q_a.pop_front());
                    stall = 1'b0;
                end else if (txv_a) begin
                    stall = 1'b1;
                    held  = txd_a;
                end else stall = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && txv_b && tx_ready) begin
                if (q_b.size() == 0) unexpected("b_extra_byte", txd_b);
                else chk8("b_byte", txd_b, q_b.pop_front());
            end
        end
    end

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < v.len; i++) begin
            logic [7:0] b;
            b = v.bytes[39-8*i -: 8];
            if (v.sel) q_b.push_back(b);
            else q_a.push_back(b);
        end
    endtask

    // Counts cycles from the one after start acceptance until done is seen.
    task automatic wait_done(input bit sel, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (sel ? done_b : done_a) begin
                got = 1'b1;
                break;
            end
        end
        chk1("done_seen", got, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        push_exp(v);
        @(posedge clk); #1;
        if (v.sel) begin start_b = 1'b1; data_b = v.data; end
        else begin start_a = 1'b1; data_a = v.data; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a = 8'($urandom);
        data_b = 8'($urandom);
        wait_done(v.sel, cyc);
        chk8("done_latency", 8'(cyc), 8'(v.len + 1));
        chk8("queue_drained", 8'(v.sel ? q_b.size() : q_a.size()), 8'd0);
        chk1("busy_after_done", v.sel ? busy_b : busy_a, 1'b0);
        @(posedge clk); #1;
        chk1("done_one_cycle", v.sel ? done_b : done_a, 1'b0);
    endtask

    initial begin
        int   cyc;
        int   st;
        vec_t v;

        vecs[0] = '{1'b0, 8'd153, 5, 40'h3135330D0A};
        vecs[1] = '{1'b0, 8'd255, 5, 40'h3235350D0A};
        vecs[2] = '{1'b0, 8'd15,  4, 40'h31350D0A00};
        vecs[3] = '{1'b0, 8'd0,   3, 40'h300D0A0000};
        vecs[4] = '{1'b0, 8'd105, 5, 40'h3130350D0A};
        vecs[5] = '{1'b0, 8'd7,   3, 40'h370D0A0000};
        vecs[6] = '{1'b0, 8'd100, 5, 40'h3130300D0A};
        vecs[7] = '{1'b1, 8'd15,  3, 40'h3031350000};
        vecs[8] = '{1'b1, 8'd0,   3, 40'h3030300000};
        vecs[9] = '{1'b1, 8'd200, 3, 40'h3230300000};

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_valid", txv_a, 1'b0);
        chk8("rst_data", txd_a, 8'h00);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_valid_b", txv_b, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // 153 with exact latency, an ignored mid-stream start, then back-to-back 42.
        push_exp(vecs[0]);
        @(posedge clk); #1;
        start_a = 1'b1; data_a = 8'd153;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk1("load_busy", busy_a, 1'b1);
        chk1("load_valid", txv_a, 1'b0);
        @(posedge clk); #1;
        chk1("first_valid", txv_a, 1'b1);
        chk8("first_byte", txd_a, 8'h31);
        start_a = 1'b1; data_a = 8'd99;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk1("done_at_n7", done_a, 1'b1);
        chk1("busy_at_n7", busy_a, 1'b0);
        v = '{1'b0, 8'd42, 4, 40'h34320D0A00};
        push_exp(v);
        start_a = 1'b1; data_a = 8'd42;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk1("b2b_busy", busy_a, 1'b1);
        wait_done(1'b0, cyc);
        chk8("b2b_latency", 8'(cyc), 8'd5);
        chk8("b2b_drained", 8'(q_a.size()), 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk1("idle_after_b2b", txv_a, 1'b0);

        // Backpressure: ready held low 5 cycles for every byte.
        push_exp(vecs[0]);
        tx_ready = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1; data_a = 8'd153;
        @(posedge clk); #1;
        start_a = 1'b0;
        st = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done_a) break;
            if (txv_a && st < 5) begin tx_ready = 1'b0; st++; end
            else if (txv_a) begin tx_ready = 1'b1; st = 0; end
            else tx_ready = 1'b0;
        end
        chk1("bp_done", done_a, 1'b1);
        chk8("bp_drained", 8'(q_a.size()), 8'd0);
        tx_ready = 1'b1;

        // Asynchronous reset while the tens byte is offered.
        push_exp(vecs[0]);
        @(posedge clk); #1;
        start_a = 1'b1; data_a = 8'd153;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        chk8("pre_rst_tens", txd_a, 8'h35);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", txv_a, 1'b0);
        chk1("async_rst_busy", busy_a, 1'b0);
        chk8("async_rst_data", txd_a, 8'h00);
        q_a.delete();
        @(posedge clk); #1;
        chk1("rst_no_done", done_a, 1'b0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        run_vec(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
